// File: rtl/wb_mem_arbiter.sv
// Two-master pipelined Wishbone arbiter: instruction cache (m0) and data cache (m1)
// share one memory slave, with frame-level round-robin grant, outstanding tracking and a watchdog.
module wb_mem_arbiter #(
  parameter int AW      = 12,
  parameter int MAX_OUT = 4,
  parameter int TIMEOUT = 255
) (
  input  logic          cpu_clock_i,
  input  logic          cpu_rst_i,
  input  logic          m0_cyc_i,
  input  logic          m0_stb_i,
  input  logic          m0_we_i,
  input  logic [AW-1:0] m0_adr_i,
  input  logic [31:0]   m0_dat_i,
  input  logic [3:0]    m0_sel_i,
  output logic          m0_stall_o,
  output logic          m0_ack_o,
  output logic          m0_err_o,
  output logic [31:0]   m0_dat_o,
  input  logic          m1_cyc_i,
  input  logic          m1_stb_i,
  input  logic          m1_we_i,
  input  logic [AW-1:0] m1_adr_i,
  input  logic [31:0]   m1_dat_i,
  input  logic [3:0]    m1_sel_i,
  output logic          m1_stall_o,
  output logic          m1_ack_o,
  output logic          m1_err_o,
  output logic [31:0]   m1_dat_o,
  output logic          wb_cyc_o,
  output logic          wb_stb_o,
  output logic          wb_we_o,
  output logic [AW-1:0] wb_adr_o,
  output logic [31:0]   wb_dat_o,
  output logic [3:0]    wb_sel_o,
  input  logic          wb_stall_i,
  input  logic          wb_ack_i,
  input  logic          wb_err_i,
  input  logic [31:0]   wb_dat_i
);

  localparam int OW = $clog2(MAX_OUT + 1);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] GNT0 = 2'd1;
  localparam logic [1:0] GNT1 = 2'd2;

  logic [1:0]    state_q, state_d;
  logic          last_q, last_d;
  logic [OW-1:0] outst_q, outst_d;
  logic [15:0]   wdog_q, wdog_d;

  logic gnt0, gnt1, granted, full, fire, resp_ok;
  logic sel_cyc, sel_stb, accept, complete;

  assign gnt0    = (state_q == GNT0);
  assign gnt1    = (state_q == GNT1);
  assign granted = gnt0 | gnt1;
  assign full    = (outst_q == OW'(MAX_OUT));
  assign resp_ok = (outst_q != '0);
  assign fire    = granted & (wdog_q == 16'(TIMEOUT));

  assign sel_cyc = (gnt0 & m0_cyc_i) | (gnt1 & m1_cyc_i);
  assign sel_stb = (gnt0 & m0_stb_i) | (gnt1 & m1_stb_i);

  // A watchdog expiry kills the whole cycle, so the strobe is suppressed with cyc.
  assign wb_cyc_o = sel_cyc & ~fire;
  assign wb_stb_o = sel_stb & ~full & ~fire;
  assign wb_we_o  = (gnt0 & m0_we_i) | (gnt1 & m1_we_i);
  assign wb_adr_o = gnt0 ? m0_adr_i : (gnt1 ? m1_adr_i : '0);
  assign wb_dat_o = gnt0 ? m0_dat_i : (gnt1 ? m1_dat_i : '0);
  assign wb_sel_o = gnt0 ? m0_sel_i : (gnt1 ? m1_sel_i : '0);

  assign m0_dat_o = wb_dat_i;
  assign m1_dat_o = wb_dat_i;

  // Responses with nothing outstanding are stale (aborted frame) and are swallowed.
  assign m0_ack_o = gnt0 & resp_ok & wb_ack_i;
  assign m1_ack_o = gnt1 & resp_ok & wb_ack_i;
  assign m0_err_o = gnt0 & ((resp_ok & wb_err_i) | fire);
  assign m1_err_o = gnt1 & ((resp_ok & wb_err_i) | fire);

  assign m0_stall_o = m0_stb_i & ~(gnt0 & ~wb_stall_i & ~full & ~fire);
  assign m1_stall_o = m1_stb_i & ~(gnt1 & ~wb_stall_i & ~full & ~fire);

  assign accept   = wb_stb_o & ~wb_stall_i;
  assign complete = granted & resp_ok & (wb_ack_i | wb_err_i);

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    outst_d = outst_q;
    wdog_d  = wdog_q;
    case (state_q)
      IDLE: begin
        outst_d = '0;
        wdog_d  = '0;
        if (m0_cyc_i && m1_cyc_i) begin
          state_d = last_q ? GNT0 : GNT1;
          last_d  = ~last_q;
        end else if (m0_cyc_i) begin
          state_d = GNT0;
          last_d  = 1'b0;
        end else if (m1_cyc_i) begin
          state_d = GNT1;
          last_d  = 1'b1;
        end
      end
      default: begin
        if (!sel_cyc || fire) begin
          state_d = IDLE;
          outst_d = '0;
          wdog_d  = '0;
        end else begin
          if (accept && !complete) begin
            outst_d = outst_q + 1'b1;
          end else if (complete && !accept) begin
            outst_d = outst_q - 1'b1;
          end
          if (accept || complete) begin
            wdog_d = '0;
          end else if (resp_ok) begin
            wdog_d = wdog_q + 16'd1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge cpu_clock_i or posedge cpu_rst_i) begin
    if (cpu_rst_i) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      outst_q <= '0;
      wdog_q  <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      outst_q <= outst_d;
      wdog_q  <= wdog_d;
    end
  end

endmodule

// File: tb/tb_wb_mem_arbiter.sv
// Bench for wb_mem_arbiter: directed scenarios with literal expectations, then random
// traffic checked every cycle against an owner/count reference model.
module tb_wb_mem_arbiter;

  localparam int AW      = 12;
  localparam int MAX_OUT = 4;
  localparam int TIMEOUT = 8;

  logic          cpu_clock_i = 1'b0;
  logic          cpu_rst_i   = 1'b0;
  logic          m0_cyc_i = 0, m0_stb_i = 0, m0_we_i = 0;
  logic [AW-1:0] m0_adr_i = '0;
  logic [31:0]   m0_dat_i = '0;
  logic [3:0]    m0_sel_i = '0;
  logic          m1_cyc_i = 0, m1_stb_i = 0, m1_we_i = 0;
  logic [AW-1:0] m1_adr_i = '0;
  logic [31:0]   m1_dat_i = '0;
  logic [3:0]    m1_sel_i = '0;
  logic          wb_stall_i = 0, wb_ack_i = 0, wb_err_i = 0;
  logic [31:0]   wb_dat_i = '0;

  logic          m0_stall_o, m0_ack_o, m0_err_o, m1_stall_o, m1_ack_o, m1_err_o;
  logic [31:0]   m0_dat_o, m1_dat_o, wb_dat_o;
  logic          wb_cyc_o, wb_stb_o, wb_we_o;
  logic [AW-1:0] wb_adr_o;
  logic [3:0]    wb_sel_o;

  wb_mem_arbiter #(.AW(AW), .MAX_OUT(MAX_OUT), .TIMEOUT(TIMEOUT)) dut (
    .cpu_clock_i(cpu_clock_i), .cpu_rst_i(cpu_rst_i),
    .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i), .m0_we_i(m0_we_i), .m0_adr_i(m0_adr_i),
    .m0_dat_i(m0_dat_i), .m0_sel_i(m0_sel_i), .m0_stall_o(m0_stall_o), .m0_ack_o(m0_ack_o),
    .m0_err_o(m0_err_o), .m0_dat_o(m0_dat_o),
    .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i), .m1_we_i(m1_we_i), .m1_adr_i(m1_adr_i),
    .m1_dat_i(m1_dat_i), .m1_sel_i(m1_sel_i), .m1_stall_o(m1_stall_o), .m1_ack_o(m1_ack_o),
    .m1_err_o(m1_err_o), .m1_dat_o(m1_dat_o),
    .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o), .wb_adr_o(wb_adr_o),
    .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o), .wb_stall_i(wb_stall_i), .wb_ack_i(wb_ack_i),
    .wb_err_i(wb_err_i), .wb_dat_i(wb_dat_i)
  );

  always #5 cpu_clock_i = ~cpu_clock_i;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  // Reference model: who owns the slave (-1 = nobody), last winner, count of
  // accepted-but-unanswered transfers, and cycles spent waiting on a response.
  int m_owner = -1;
  int m_last  = 1;
  int m_outst = 0;
  int m_idle  = 0;

  logic          o_cyc, o_stb, e_fire, e_full, e_acc, e_cmp;
  logic          e_cyc, e_stb, e_we, e_ack0, e_ack1, e_err0, e_err1, e_stall0, e_stall1;
  logic [AW-1:0] e_adr;
  logic [31:0]   e_dat;
  logic [3:0]    e_sel;

  always_comb begin
    o_cyc = 1'b0; o_stb = 1'b0; e_we = 1'b0; e_adr = '0; e_dat = '0; e_sel = '0;
    if (m_owner == 0) begin
      o_cyc = m0_cyc_i; o_stb = m0_stb_i; e_we = m0_we_i;
      e_adr = m0_adr_i; e_dat = m0_dat_i; e_sel = m0_sel_i;
    end else if (m_owner == 1) begin
      o_cyc = m1_cyc_i; o_stb = m1_stb_i; e_we = m1_we_i;
      e_adr = m1_adr_i; e_dat = m1_dat_i; e_sel = m1_sel_i;
    end
    e_fire   = (m_owner >= 0) && (m_idle == TIMEOUT);
    e_full   = (m_outst == MAX_OUT);
    e_cyc    = o_cyc && !e_fire;
    e_stb    = o_stb && !e_full && !e_fire;
    e_ack0   = (m_owner == 0) && wb_ack_i && (m_outst > 0);
    e_ack1   = (m_owner == 1) && wb_ack_i && (m_outst > 0);
    e_err0   = (m_owner == 0) && ((wb_err_i && (m_outst > 0)) || e_fire);
    e_err1   = (m_owner == 1) && ((wb_err_i && (m_outst > 0)) || e_fire);
    e_stall0 = m0_stb_i && !((m_owner == 0) && !wb_stall_i && !e_full && !e_fire);
    e_stall1 = m1_stb_i && !((m_owner == 1) && !wb_stall_i && !e_full && !e_fire);
    e_acc    = e_stb && !wb_stall_i;
    e_cmp    = (m_owner >= 0) && (m_outst > 0) && (wb_ack_i || wb_err_i);
  end

  always @(posedge cpu_clock_i or posedge cpu_rst_i) begin
    if (cpu_rst_i) begin
      m_owner <= -1; m_last <= 1; m_outst <= 0; m_idle <= 0;
    end else if (m_owner < 0) begin
      if (m0_cyc_i && m1_cyc_i) begin
        m_owner <= 1 - m_last; m_last <= 1 - m_last;
      end else if (m0_cyc_i) begin
        m_owner <= 0; m_last <= 0;
      end else if (m1_cyc_i) begin
        m_owner <= 1; m_last <= 1;
      end
    end else if (!o_cyc || e_fire) begin
      m_owner <= -1; m_outst <= 0; m_idle <= 0;
    end else begin
      m_outst <= m_outst + int'(e_acc) - int'(e_cmp);
      if (e_acc || e_cmp) m_idle <= 0;
      else if (m_outst > 0) m_idle <= m_idle + 1;
    end
  end

  always @(negedge cpu_clock_i) begin
    chk("wb_cyc", 64'(wb_cyc_o), 64'(e_cyc));
    chk("wb_stb", 64'(wb_stb_o), 64'(e_stb));
    chk("wb_we", 64'(wb_we_o), 64'(e_we));
    chk("wb_adr", 64'(wb_adr_o), 64'(e_adr));
    chk("wb_dat", 64'(wb_dat_o), 64'(e_dat));
    chk("wb_sel", 64'(wb_sel_o), 64'(e_sel));
    chk("m0_ack", 64'(m0_ack_o), 64'(e_ack0));
    chk("m1_ack", 64'(m1_ack_o), 64'(e_ack1));
    chk("m0_err", 64'(m0_err_o), 64'(e_err0));
    chk("m1_err", 64'(m1_err_o), 64'(e_err1));
    chk("m0_stall", 64'(m0_stall_o), 64'(e_stall0));
    chk("m1_stall", 64'(m1_stall_o), 64'(e_stall1));
    chk("m0_dat", 64'(m0_dat_o), 64'(wb_dat_i));
    chk("m1_dat", 64'(m1_dat_o), 64'(wb_dat_i));
  end

  task automatic tick();
    @(posedge cpu_clock_i);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic do_reset();
    cpu_rst_i = 1'b1;
    tick();
    cpu_rst_i = 1'b0;
  endtask

  int ackp;

  initial begin
    // reset state
    #1 cpu_rst_i = 1'b1;
    m0_stb_i = 1'b1;
    #2;
    chk("lit_rst_cyc", 64'(wb_cyc_o), 64'd0);
    chk("lit_rst_stb", 64'(wb_stb_o), 64'd0);
    chk("lit_rst_stall", 64'(m0_stall_o), 64'd1);
    tick(); tick();
    cpu_rst_i = 1'b0; m0_stb_i = 1'b0;

    // single m0 read, zero-wait slave
    tick();
    m0_cyc_i = 1; m0_stb_i = 1; m0_adr_i = 12'h010; settle();
    chk("lit_rd_stall_n", 64'(m0_stall_o), 64'd1);
    chk("lit_rd_stb_n", 64'(wb_stb_o), 64'd0);
    tick();
    chk("lit_rd_stb_n1", 64'(wb_stb_o), 64'd1);
    chk("lit_rd_adr_n1", 64'(wb_adr_o), 64'h010);
    chk("lit_rd_stall_n1", 64'(m0_stall_o), 64'd0);
    tick();
    m0_stb_i = 0; wb_ack_i = 1; wb_dat_i = 32'hCAFE_F00D; settle();
    chk("lit_rd_ack", 64'(m0_ack_o), 64'd1);
    chk("lit_rd_dat", 64'(m0_dat_o), 64'hCAFE_F00D);
    chk("lit_rd_m1_ack", 64'(m1_ack_o), 64'd0);
    tick();
    wb_ack_i = 0; m0_cyc_i = 0;
    tick();

    // simultaneous requests after reset, then a second tie
    do_reset();
    tick();
    m0_cyc_i = 1; m0_stb_i = 1; m0_adr_i = 12'h111;
    m1_cyc_i = 1; m1_stb_i = 1; m1_adr_i = 12'h222; settle();
    chk("lit_tie_stall0", 64'(m0_stall_o), 64'd1);
    chk("lit_tie_stall1", 64'(m1_stall_o), 64'd1);
    tick();
    chk("lit_tie_adr_m0", 64'(wb_adr_o), 64'h111);
    chk("lit_tie_m1_stalled", 64'(m1_stall_o), 64'd1);
    tick();
    m0_cyc_i = 0; m0_stb_i = 0; m1_cyc_i = 0; m1_stb_i = 0;
    tick();
    m0_cyc_i = 1; m0_stb_i = 1; m1_cyc_i = 1; m1_stb_i = 1; settle();
    chk("lit_tie2_idle_cyc", 64'(wb_cyc_o), 64'd0);
    tick();
    chk("lit_tie2_adr_m1", 64'(wb_adr_o), 64'h222);
    chk("lit_tie2_m0_stalled", 64'(m0_stall_o), 64'd1);
    tick();
    m1_cyc_i = 0; m1_stb_i = 0; settle();
    chk("lit_hand_drop_stall", 64'(m0_stall_o), 64'd1);
    tick();
    chk("lit_hand_idle_stall", 64'(m0_stall_o), 64'd1);
    chk("lit_hand_idle_cyc", 64'(wb_cyc_o), 64'd0);
    tick();
    chk("lit_hand_adr_m0", 64'(wb_adr_o), 64'h111);
    chk("lit_hand_stall0", 64'(m0_stall_o), 64'd0);
    tick();
    m0_cyc_i = 0; m0_stb_i = 0;
    tick();

    // watchdog: four accepts, no acks, TIMEOUT=8
    do_reset();
    tick();
    m0_cyc_i = 1; m0_stb_i = 1; m0_adr_i = 12'h300;
    for (int k = 1; k <= 14; k++) begin
      tick();
      if (k == 5) begin
        chk("lit_wd_full_stall", 64'(m0_stall_o), 64'd1);
        chk("lit_wd_full_stb", 64'(wb_stb_o), 64'd0);
      end
      if (k == 12) begin
        chk("lit_wd_pre_err", 64'(m0_err_o), 64'd0);
        chk("lit_wd_pre_cyc", 64'(wb_cyc_o), 64'd1);
      end
      if (k == 13) begin
        chk("lit_wd_err", 64'(m0_err_o), 64'd1);
        chk("lit_wd_cyc", 64'(wb_cyc_o), 64'd0);
      end
      if (k == 14) begin
        chk("lit_wd_post_err", 64'(m0_err_o), 64'd0);
        chk("lit_wd_post_cyc", 64'(wb_cyc_o), 64'd0);
      end
    end
    tick();
    m0_cyc_i = 0; m0_stb_i = 0;
    tick();

    // abort with two outstanding; late acks must vanish
    tick();
    m0_cyc_i = 1; m0_stb_i = 1;
    tick(); tick();
    tick();
    m0_cyc_i = 0; m0_stb_i = 0;
    tick();
    wb_ack_i = 1; m1_cyc_i = 1; settle();
    chk("lit_abort_m0_ack", 64'(m0_ack_o), 64'd0);
    chk("lit_abort_m1_ack_idle", 64'(m1_ack_o), 64'd0);
    tick();
    chk("lit_abort_m1_ack_gnt", 64'(m1_ack_o), 64'd0);
    tick();
    wb_ack_i = 0; m1_stb_i = 1; m1_adr_i = 12'h0AB; settle();
    chk("lit_abort_m1_stb", 64'(wb_stb_o), 64'd1);
    tick();
    m1_cyc_i = 0; m1_stb_i = 0;
    tick();

    // async reset mid-burst
    tick();
    m0_cyc_i = 1; m0_stb_i = 1;
    tick();
    chk("lit_ar_cyc_before", 64'(wb_cyc_o), 64'd1);
    #1 cpu_rst_i = 1'b1;
    #1;
    chk("lit_ar_cyc", 64'(wb_cyc_o), 64'd0);
    chk("lit_ar_stb", 64'(wb_stb_o), 64'd0);
    tick();
    cpu_rst_i = 1'b0; m0_cyc_i = 0; m0_stb_i = 0;

    // random traffic; alternate a responsive slave with a sluggish one
    ackp = 30;
    for (int c = 0; c < 4000; c++) begin
      tick();
      if (c % 250 == 0) ackp = (ackp == 30) ? 2 : 30;
      if ($urandom_range(0, 23) == 0) m0_cyc_i = ~m0_cyc_i;
      if ($urandom_range(0, 23) == 0) m1_cyc_i = ~m1_cyc_i;
      m0_stb_i = m0_cyc_i & ($urandom_range(0, 1) == 1);
      m1_stb_i = m1_cyc_i & ($urandom_range(0, 1) == 1);
      m0_we_i = ($urandom_range(0, 1) == 1);
      m1_we_i = ($urandom_range(0, 1) == 1);
      m0_adr_i = AW'($urandom); m1_adr_i = AW'($urandom);
      m0_dat_i = $urandom; m1_dat_i = $urandom;
      m0_sel_i = 4'($urandom); m1_sel_i = 4'($urandom);
      wb_stall_i = ($urandom_range(0, 3) == 0);
      wb_ack_i = ($urandom_range(0, 99) < ackp);
      wb_err_i = ($urandom_range(0, 99) < 2);
      wb_dat_i = $urandom;
    end
    tick(); tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
